horner_eval: RTL and testbench
==============================

# horner_eval

Iterative, parametrised polynomial function evaluator: computes f(x) = p0 + x·(p1 + x·(p2 + …)) in Q(FB) fixed point by Horner's rule, one multiply-accumulate per clock on a single shared multiplier. It holds NF run-time-loadable coefficient banks of up to degree N; each request selects a bank and a degree. It sits in the arithmetic datapath next to the fixed ln/exp approximators and replaces them where several functions, or a changeable degree, are needed. Valid/ready handshakes are used on input and output.

## Interface
- W, 18: data and coefficient width, signed two's complement.
- N, 5: maximum polynomial degree; each bank holds N+1 coefficients.
- FB, 16: fractional bits of x, coefficients and result.
- NF, 2: number of coefficient banks.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle and able to accept.
- x_in  in  W  argument, signed Q(FB).
- sel_in  in  max(1,$clog2(NF))  coefficient bank select.
- deg_in  in  $clog2(N+1)  polynomial degree for this request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y_out  out  W  result, signed Q(FB).
- coef_we  in  1  coefficient write strobe.
- coef_bank  in  max(1,$clog2(NF))  bank to write.
- coef_idx  in  $clog2(N+1)  coefficient index k (pk).
- coef_data  in  W  coefficient value.
- coef_err  out  1  one-cycle pulse: the write was dropped.

## Operation
- Reset state: IDLE; in_ready=1; out_valid=0; y_out=0; coef_err=0; all internal registers 0.
- Reset coefficients: bank 0 = {1, 65481, −32093, 18601, −8517, 1954} for p0..p5, i.e. ln(1+x) for 0≤x≤1. Index k>5 and all other banks reset to 0.
- FSM states: IDLE, MAC, DONE.
- IDLE: in_ready=1. Accept when in_valid=1, which latches x, sel and deg.
  - deg_in>N is clamped to N.
  - sel_in≥NF selects bank 0.
  - The accumulator s loads p[sel][deg] and k loads deg−1.
  - If deg=0, go to DONE with y_out=p[sel][0]. Otherwise go to MAC.
- MAC: each cycle s ← ((x·s) >>> FB) + p[sel][k].
  - x·s is a full 2W-bit signed product. The shift is arithmetic, truncating toward −∞.
  - The sum is truncated to W bits and wraps; there is no saturation.
  - When k=0, load y_out with the new s and go to DONE. Otherwise decrement k.
- DONE: out_valid=1 and y_out is stable. When out_ready=1, go to IDLE and drop out_valid on that edge.
- Coefficient writes:
  - A write in IDLE updates the bank at that edge.
  - A write in MAC or DONE is dropped, and coef_err pulses high for the next cycle.
  - A write and an accept in the same IDLE cycle: the write commits, and the new request uses the pre-write value for that cycle's p[sel][deg] load and the written value afterwards.
- Reset mid-operation aborts the evaluation immediately and restores all reset values, including the coefficient banks.

## Timing
- Call the accept cycle cycle 0. out_valid is first high in cycle deg+1: deg 0 gives cycle 1, deg 5 gives cycle 6.
- in_ready is high only in IDLE. The minimum request period is deg+2 cycles, with out_ready held high.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE and causes no state change.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- HORNER_ROUND_EN defined:
  - Every MAC step uses round-half-up: ((x·s) + 2^(FB−1)) >>> FB.
  - The deg=0 path is unaffected.
- HORNER_ROUND_EN undefined: every MAC step truncates with a plain >>> FB.

## Test plan
- Truncation: after reset, x_in=32768 (0.5), sel=0, deg=5 → out_valid in cycle 6, y_out=26572. With HORNER_ROUND_EN defined → y_out=26573.
- Exact arguments: x_in=65536, sel=0, deg=5 → y_out=45427 in both modes. x_in=0, deg=5 → y_out=1.
- Degree 0 and clamping: deg=0, sel=0, x_in=32768 → y_out=1, out_valid in cycle 1. With N=5, deg_in=7 behaves exactly as deg=5.
- Back-pressure: out_ready held low for 10 cycles after out_valid → y_out stays stable, in_ready=0, extra in_valid pulses are ignored. Raising out_ready → in_ready=1 the next cycle.
- Coefficient load: in IDLE, write bank 1 as p0=0, p1=65536, p2=65536 (x+x²). Then x_in=32768, sel=1, deg=2 → y_out=49152.
  - A write issued during MAC → coef_err pulse, and a re-run returns the unchanged result.
- Reset mid-evaluation: assert reset in cycle 3 of a deg=5 request → out_valid=0, y_out=0, in_ready=1 after release. Bank 0 is restored: the next x=32768 request returns 26572.

Source files
------------

// File: rtl/horner_eval_if.sv
// Request/result handshake and coefficient-write bus for horner_eval.
// The master side issues requests and coefficient writes; the slave side is the evaluator.
interface horner_eval_if #(
    parameter int W  = 18,
    parameter int N  = 5,
    parameter int NF = 2
);
    localparam int SW = (NF > 1) ? $clog2(NF) : 1;
    localparam int DW = (N > 0) ? $clog2(N + 1) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  x_in;
    logic [SW-1:0]        sel_in;
    logic [DW-1:0]        deg_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  y_out;
    logic                 coef_we;
    logic [SW-1:0]        coef_bank;
    logic [DW-1:0]        coef_idx;
    logic signed [W-1:0]  coef_data;
    logic                 coef_err;

    modport master (
        output in_valid, x_in, sel_in, deg_in, out_ready,
        output coef_we, coef_bank, coef_idx, coef_data,
        input  in_ready, out_valid, y_out, coef_err
    );

    modport slave (
        input  in_valid, x_in, sel_in, deg_in, out_ready,
        input  coef_we, coef_bank, coef_idx, coef_data,
        output in_ready, out_valid, y_out, coef_err
    );
endinterface

// File: rtl/horner_eval.sv
// Iterative Horner-rule polynomial evaluator, one shared multiply-accumulate per clock.
// Define HORNER_ROUND_EN to round half-up on every MAC step instead of truncating.
module horner_eval #(
    parameter int W  = 18,
    parameter int N  = 5,
    parameter int FB = 16,
    parameter int NF = 2
) (
    input  logic           clk,
    input  logic           reset,
    horner_eval_if.slave   bus
);
    localparam int SW = (NF > 1) ? $clog2(NF) : 1;
    localparam int DW = (N > 0) ? $clog2(N + 1) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t               state, next_state;
    logic signed [W-1:0]  coef [NF][N+1];
    logic signed [W-1:0]  x_reg, s_reg, y_reg;
    logic [SW-1:0]        sel_reg;
    logic [DW-1:0]        k_reg;
    logic                 coef_err_reg;

    logic [SW-1:0]          sel_eff;
    logic [DW-1:0]          deg_eff;
    logic                   coef_wr_ok;
    logic signed [2*W-1:0]  prod, prod_adj;
    logic signed [W-1:0]    mac_sum;

    // Bank 0 powers up as ln(1+x) on [0,1]; everything else starts at zero.
    function automatic logic signed [W-1:0] reset_coef(input int bank, input int idx);
        logic signed [W-1:0] v;
        v = '0;
        if (bank == 0) begin
            case (idx)
                0: v = W'(1);
                1: v = W'(65481);
                2: v = W'(-32093);
                3: v = W'(18601);
                4: v = W'(-8517);
                5: v = W'(1954);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    always_comb begin
        sel_eff = bus.sel_in;
        if ({1'b0, bus.sel_in} >= (SW+1)'(NF))
            sel_eff = '0;
        deg_eff = bus.deg_in;
        if (bus.deg_in > DW'(N))
            deg_eff = DW'(N);
        coef_wr_ok = ({1'b0, bus.coef_bank} < (SW+1)'(NF)) &&
                     ({1'b0, bus.coef_idx} <= (DW+1)'(N));
    end

    always_comb begin
        prod = (2*W)'(x_reg) * (2*W)'(s_reg);
`ifdef HORNER_ROUND_EN
        prod_adj = prod + ((2*W)'(1) <<< (FB - 1));
`else
        prod_adj = prod;
`endif
        mac_sum = W'(prod_adj >>> FB) + coef[sel_reg][k_reg];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid) next_state = (deg_eff == '0) ? DONE : MAC;
            MAC:  if (k_reg == '0) next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // The accept-cycle load reads the bank before any same-cycle write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg        <= '0;
            s_reg        <= '0;
            y_reg        <= '0;
            sel_reg      <= '0;
            k_reg        <= '0;
            coef_err_reg <= 1'b0;
        end else begin
            coef_err_reg <= bus.coef_we && (state != IDLE);
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_reg   <= bus.x_in;
                    sel_reg <= sel_eff;
                    s_reg   <= coef[sel_eff][deg_eff];
                    k_reg   <= deg_eff - DW'(1);
                    if (deg_eff == '0)
                        y_reg <= coef[sel_eff][0];
                end
                MAC: begin
                    s_reg <= mac_sum;
                    if (k_reg == '0) y_reg <= mac_sum;
                    else             k_reg <= k_reg - DW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NF; b++)
                for (int i = 0; i <= N; i++)
                    coef[b][i] <= reset_coef(b, i);
        end else if (bus.coef_we && (state == IDLE) && coef_wr_ok) begin
            coef[bus.coef_bank][bus.coef_idx] <= bus.coef_data;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y_out     = y_reg;
    assign bus.coef_err  = coef_err_reg;
endmodule

// File: tb/tb_horner_eval.sv
// Randomised scoreboard bench for horner_eval against an integer Horner model.
// Honours HORNER_ROUND_EN the same way as the design.
module tb_horner_eval;
    localparam int W  = 18;
    localparam int N  = 5;
    localparam int FB = 16;
    localparam int NF = 2;
    localparam int SW = (NF > 1) ? $clog2(NF) : 1;
    localparam int DW = (N > 0) ? $clog2(N + 1) : 1;
`ifdef HORNER_ROUND_EN
    localparam int Y_HALF = 26573;
`else
    localparam int Y_HALF = 26572;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    horner_eval_if #(.W(W), .N(N), .NF(NF)) bus ();

    horner_eval #(.W(W), .N(N), .FB(FB), .NF(NF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mdl [NF][N+1];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int wrapw(input longint v);
        longint m;
        m = v & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W - 1)))
            m = m - (longint'(1) << W);
        return int'(m);
    endfunction

    function automatic void initModel();
        for (int b = 0; b < NF; b++)
            for (int i = 0; i <= N; i++)
                mdl[b][i] = 0;
        mdl[0] = '{1, 65481, -32093, 18601, -8517, 1954};
    endfunction

    // f = p0 + x(p1 + x(p2 + ...)) with the top term supplied separately.
    function automatic int ref_eval(input int x, input int sel, input int deg, input int top);
        longint s, p;
        s = top;
        for (int k = deg - 1; k >= 0; k--) begin
            p = longint'(x) * s;
`ifdef HORNER_ROUND_EN
            p = p + (longint'(1) << (FB - 1));
`endif
            s = wrapw((p >>> FB) + longint'(mdl[sel][k]));
        end
        return int'(s);
    endfunction

    function automatic int clampSel(input int sel);
        return (sel >= NF) ? 0 : sel;
    endfunction

    function automatic int clampDeg(input int deg);
        return (deg > N) ? N : deg;
    endfunction

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
                checkOutput("unexpected result", 1, 0);
            else
                checkOutput("scoreboard y_out", $signed(bus.y_out), exp_q.pop_front());
        end
    end

    task automatic applyStimulus(input int x, input int sel, input int deg,
                                 input bit wr, input int widx, input int wdata);
        int n, se, de, top;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) checkOutput("in_ready wait", 0, 1);
        se  = clampSel(sel);
        de  = clampDeg(deg);
        top = mdl[se][de];
        bus.in_valid = 1'b1;
        bus.x_in     = W'(x);
        bus.sel_in   = SW'(sel);
        bus.deg_in   = DW'(deg);
        if (wr) begin
            bus.coef_we   = 1'b1;
            bus.coef_bank = SW'(se);
            bus.coef_idx  = DW'(widx);
            bus.coef_data = W'(wdata);
            mdl[se][widx] = wrapw(longint'(wdata));
        end
        exp_q.push_back(ref_eval(wrapw(longint'(x)), se, de, top));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
    endtask

    task automatic waitResult(input int start, input int deg_e, output int y);
        int n;
        n = start;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, deg_e + 1);
        y = $signed(bus.y_out);
    endtask

    task automatic runReq(input int x, input int sel, input int deg, input int hold, output int y);
        bus.out_ready = (hold == 0);
        applyStimulus(x, sel, deg, 1'b0, 0, 0);
        waitResult(1, clampDeg(deg), y);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready after handshake", bus.in_ready, 1);
    endtask

    task automatic writeCoef(input int bank, input int idx, input int data);
        bus.coef_we   = 1'b1;
        bus.coef_bank = SW'(bank);
        bus.coef_idx  = DW'(idx);
        bus.coef_data = W'(data);
        mdl[bank][idx] = wrapw(longint'(data));
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        checkOutput("coef_err on idle write", bus.coef_err, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int y;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.sel_in    = '0;
        bus.deg_in    = '0;
        bus.out_ready = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_bank = '0;
        bus.coef_idx  = '0;
        bus.coef_data = '0;
        initModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset y_out", $signed(bus.y_out), 0);
        checkOutput("reset coef_err", bus.coef_err, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        runReq(32768, 0, 5, 0, y);
        checkOutput("ln x=0.5 deg5", y, Y_HALF);
        runReq(65536, 0, 5, 0, y);
        checkOutput("ln x=1.0 deg5", y, 45427);
        runReq(0, 0, 5, 0, y);
        checkOutput("ln x=0 deg5", y, 1);
        runReq(32768, 0, 0, 0, y);
        checkOutput("deg0 y_out", y, 1);
        runReq(-20000, 0, 7, 0, y);
        runReq(50000, 0, 7, 2, y);

        // Hold the result under back-pressure while stray requests arrive.
        bus.out_ready = 1'b0;
        applyStimulus(32768, 0, 5, 1'b0, 0, 0);
        waitResult(1, 5, y);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                bus.in_valid = 1'b1;
                bus.x_in     = W'(12345);
                bus.deg_in   = '0;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            checkOutput("bp y_out stable", $signed(bus.y_out), Y_HALF);
            checkOutput("bp in_ready", bus.in_ready, 0);
            checkOutput("bp out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release in_ready", bus.in_ready, 1);
        checkOutput("bp release out_valid", bus.out_valid, 0);

        writeCoef(1, 0, 0);
        writeCoef(1, 1, 65536);
        writeCoef(1, 2, 65536);
        runReq(32768, 1, 2, 0, y);
        checkOutput("x+x^2 at 0.5", y, 49152);

        bus.out_ready = 1'b1;
        applyStimulus(32768, 1, 2, 1'b0, 0, 0);
        bus.coef_we   = 1'b1;
        bus.coef_bank = SW'(1);
        bus.coef_idx  = DW'(1);
        bus.coef_data = W'(777);
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        checkOutput("coef_err pulse", bus.coef_err, 1);
        waitResult(2, 2, y);
        checkOutput("coef_err one cycle", bus.coef_err, 0);
        checkOutput("result with dropped write", y, 49152);
        @(posedge clk); #1;
        runReq(32768, 1, 2, 0, y);
        checkOutput("rerun after dropped write", y, 49152);

        bus.out_ready = 1'b1;
        applyStimulus(32768, 1, 2, 1'b1, 2, 32768);
        waitResult(1, 2, y);
        checkOutput("write+accept uses old top", y, 49152);
        @(posedge clk); #1;
        runReq(32768, 1, 2, 0, y);
        checkOutput("new top after write", y, 40960);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                writeCoef(int'($urandom_range(0, NF - 1)), int'($urandom_range(0, N)),
                          int'($urandom_range(0, 262143)) - 131072);
            runReq(int'($urandom_range(0, 262143)) - 131072,
                   int'($urandom_range(0, NF - 1)),
                   int'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)), y);
        end

        // Abort a deg-5 evaluation in cycle 3 and confirm bank 0 comes back.
        bus.out_ready = 1'b1;
        applyStimulus(32768, 0, 5, 1'b0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("mid reset out_valid", bus.out_valid, 0);
        checkOutput("mid reset y_out", $signed(bus.y_out), 0);
        checkOutput("mid reset in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        initModel();
        @(posedge clk); #1;
        checkOutput("post reset in_ready", bus.in_ready, 1);
        runReq(32768, 0, 5, 0, y);
        checkOutput("bank0 restored", y, Y_HALF);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
